// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } nsa_state_t;

endpackage

// File: rtl/nibble_add_slice.sv
// One 4-bit adder slice with carry-in and carry-out.
// Latency: purely combinational.
// Backpressure: none, always produces a result.
module nibble_add_slice
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  // Zero-extend everything to NIB_W+1 bits so the carry lands in the top bit.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that walks WIDTH-bit operands through one nibble slice, LSB nibble first.
// Latency: result valid NIBBLES edges after the input handshake; one op per NIBBLES+2 cycles.
// Backpressure: out_ready low holds the result in DONE; in_ready stays low until it drains.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  nsa_state_t       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [NIB_W-1:0] nib_s;
  logic             nib_c;

  // Single shared slice; the low nibbles of the shift registers feed it each RUN cycle.
  nibble_add_slice u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  assign in_ready = (state == S_IDLE) & ~rst;

  // Insert the fresh nibble at the top of the sum register; written as a shift plus
  // part-select so it stays legal when WIDTH is a single nibble.
  always_comb begin
    sum_next = sum_sh >> NIB_W;
    sum_next[WIDTH-1 -: NIB_W] = nib_s;
  end

  // Control FSM plus datapath registers; outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> NIB_W;
          b_sh   <= b_sh >> NIB_W;
          carry  <= nib_c;
          sum_sh <= sum_next;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_cout  <= nib_c;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for the nibble-serial adder: directed cases plus a random streaming run.
// Latency: n/a.
// Backpressure: random out_ready in the streaming run.
module tb_nibble_serial_adder;

  localparam int W     = 32;
  localparam int NIB   = W / 4;
  localparam int N_OPS = 2000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_cin, out_valid, out_ready, out_cout;
  logic [W-1:0]  in_a, in_b, out_sum;

  logic          n4_in_valid, n4_in_ready, n4_in_cin, n4_out_valid, n4_out_ready, n4_out_cout;
  logic [3:0]    n4_in_a, n4_in_b, n4_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(n4_in_valid), .in_ready(n4_in_ready),
    .in_a(n4_in_a), .in_b(n4_in_b), .in_cin(n4_in_cin),
    .out_valid(n4_out_valid), .out_ready(n4_out_ready),
    .out_sum(n4_out_sum), .out_cout(n4_out_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) check("start_timeout", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] held;
    int           lat;
    logic [W:0]   sb[$];
    int           sent, recv, cyc;
    logic         acc, del;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    n4_in_valid = 1'b0; n4_in_a = '0; n4_in_b = '0; n4_in_cin = 1'b0; n4_out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_out_cout",  64'(out_cout),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Case 1: full carry ripple, latency exactly NIB edges.
    start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_out(lat);
    check("c1_latency", 64'(lat), 64'(NIB));
    check("c1_sum",  64'(out_sum),  64'h0);
    check("c1_cout", 64'(out_cout), 64'd1);
    tick();
    check("c1_drain_valid", 64'(out_valid), 64'd0);

    // Case 2: carry-in only, then a mixed-pattern pair.
    start_op('0, '0, 1'b1);
    wait_out(lat);
    check("c2a_sum",  64'(out_sum),  64'h1);
    check("c2a_cout", 64'(out_cout), 64'd0);
    tick();
    start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    wait_out(lat);
    check("c2b_sum",  64'(out_sum),  64'hACF1_3568);
    check("c2b_cout", 64'(out_cout), 64'd0);
    tick();

    // Case 3: backpressure holds the result and blocks new input.
    out_ready = 1'b0;
    start_op(32'h8000_0000, 32'h8000_0005, 1'b1);
    wait_out(lat);
    exp  = ref_add(32'h8000_0000, 32'h8000_0005, 1'b1);
    held = out_sum;
    check("c3_sum", {31'd0, out_cout, out_sum}, 64'(exp));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("c3_hold_valid", 64'(out_valid), 64'd1);
      check("c3_hold_sum",   64'(out_sum),   64'(held));
      check("c3_hold_ready", 64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("c3_ready_before_hs", 64'(in_ready), 64'd0);
    tick();
    check("c3_valid_dropped", 64'(out_valid), 64'd0);
    check("c3_ready_back",    64'(in_ready),  64'd1);

    // Case 4: reset at idx=3 discards the op.
    start_op(32'h0F0F_0F0F, 32'h1111_1111, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("c4_ready_in_rst", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("c4_valid", 64'(out_valid), 64'd0);
    check("c4_sum",   64'(out_sum),   64'd0);
    check("c4_ready", 64'(in_ready),  64'd1);
    for (int i = 0; i < NIB + 2; i++) begin
      tick();
      check("c4_no_stale_result", 64'(out_valid), 64'd0);
    end
    start_op(32'd1, 32'd1, 1'b0);
    wait_out(lat);
    check("c4_new_sum", 64'(out_sum), 64'd2);
    tick();

    // rst together with in_valid: nothing is accepted.
    rst = 1'b1; in_valid = 1'b1; in_a = 32'd7; in_b = 32'd7;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NIB + 2; i++) tick();
    check("rst_vs_valid_no_result", 64'(out_valid), 64'd0);

    // Case 5: single-nibble build, one RUN cycle.
    n4_in_a = 4'hF; n4_in_b = 4'hF; n4_in_cin = 1'b1; n4_in_valid = 1'b1;
    #1;
    check("c5_in_ready", 64'(n4_in_ready), 64'd1);
    tick();
    n4_in_valid = 1'b0;
    check("c5_not_yet", 64'(n4_out_valid), 64'd0);
    tick();
    check("c5_valid", 64'(n4_out_valid), 64'd1);
    check("c5_sum",   64'(n4_out_sum),   64'hF);
    check("c5_cout",  64'(n4_out_cout),  64'd1);
    tick();

    // Case 6: random streaming with random out_ready and an in-order scoreboard.
    sent = 0; recv = 0; cyc = 0;
    in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
    while (recv < N_OPS && cyc < 60000) begin
      if (sent < N_OPS) in_valid = ($urandom_range(3) != 0);
      else              in_valid = 1'b0;
      out_ready = 1'($urandom);
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
        if (sb.size() == 0) begin
          check("c6_spurious_result", 64'(out_valid), 64'd0);
        end else begin
          exp = sb.pop_front();
          check("c6_result", {31'd0, out_cout, out_sum}, 64'(exp));
        end
        recv++;
      end
      if (acc) begin
        sb.push_back(ref_add(in_a, in_b, in_cin));
        sent++;
      end
      tick();
      cyc++;
      if (acc) begin
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    check("c6_all_received", 64'(recv), 64'(N_OPS));
    check("c6_queue_empty",  64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
